// File: rtl/turn_signal_pkg.sv
// rtl/turn_signal_pkg.sv - shared turn-signal lamp encodings, state indices and fault codes
package turn_signal_pkg;

    // Lamp patterns as seen on Lights[1:6], Lights[1] is the leftmost bit.
    localparam logic [5:0] PAT_IDLE = 6'b000000;
    localparam logic [5:0] PAT_L1   = 6'b100000;
    localparam logic [5:0] PAT_L2   = 6'b110000;
    localparam logic [5:0] PAT_L3   = 6'b111000;
    localparam logic [5:0] PAT_R1   = 6'b000001;
    localparam logic [5:0] PAT_R2   = 6'b000011;
    localparam logic [5:0] PAT_R3   = 6'b000111;
    localparam logic [5:0] PAT_LR3  = 6'b111111;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_PATTERN = 2'd1;
    localparam logic [1:0] FC_TRANS   = 2'd2;
    localparam logic [1:0] FC_HOLD    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_L1   = 3'd1,
        S_L2   = 3'd2,
        S_L3   = 3'd3,
        S_R1   = 3'd4,
        S_R2   = 3'd5,
        S_R3   = 3'd6,
        S_LR3  = 3'd7
    } state_e;

    // Step-to-step legality only; repeating the same non-idle pattern is
    // handled by the hold counter in the checker.
    function automatic logic trans_legal(input state_e prev, input state_e cur);
        logic ok;
        ok = 1'b0;
        case (prev)
            S_IDLE: ok = (cur == S_IDLE) || (cur == S_L1) || (cur == S_R1) || (cur == S_LR3);
            S_L1:   ok = (cur == S_L2) || (cur == S_LR3);
            S_L2:   ok = (cur == S_L3) || (cur == S_LR3);
            S_L3:   ok = (cur == S_IDLE);
            S_R1:   ok = (cur == S_R2) || (cur == S_LR3);
            S_R2:   ok = (cur == S_R3) || (cur == S_LR3);
            S_R3:   ok = (cur == S_IDLE);
            S_LR3:  ok = (cur == S_IDLE);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/turn_signal_pattern_decode.sv
// rtl/turn_signal_pattern_decode.sv - combinational lamp pattern to state index decoder
// Ports: pattern (6-bit lamp value in), state_idx (3-bit state index out),
//        valid (1 when pattern is one of the eight legal codes).
module turn_signal_pattern_decode
    import turn_signal_pkg::*;
(
    input  logic [5:0] pattern,
    output logic [2:0] state_idx,
    output logic       valid
);

    always_comb begin
        state_idx = S_IDLE;
        valid     = 1'b1;
        case (pattern)
            PAT_IDLE: state_idx = S_IDLE;
            PAT_L1:   state_idx = S_L1;
            PAT_L2:   state_idx = S_L2;
            PAT_L3:   state_idx = S_L3;
            PAT_R1:   state_idx = S_R1;
            PAT_R2:   state_idx = S_R2;
            PAT_R3:   state_idx = S_R3;
            PAT_LR3:  state_idx = S_LR3;
            default: begin
                state_idx = S_IDLE;
                valid     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/turn_signal_monitor.sv
// rtl/turn_signal_monitor.sv - receive-side checker for the turn-signal lamp bus
// Ports: CLOCK, RESET_N (sync active-low), Lights[1:6] observed lamps, CLEAR fault clear;
//        Left/Right/HazardActive decoded state, Left/Right/HazardDone completion pulses,
//        Fault sticky flag, FaultCode first fault, SeqCount saturating completion count.
module turn_signal_monitor
    import turn_signal_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int MAX_HOLD = 1
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic [1:6]       Lights,
    input  logic             CLEAR,
    output logic             LeftActive,
    output logic             RightActive,
    output logic             HazardActive,
    output logic             LeftDone,
    output logic             RightDone,
    output logic             HazardDone,
    output logic             Fault,
    output logic [1:0]       FaultCode,
    output logic [CNT_W-1:0] SeqCount
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

    logic [2:0]        cur_raw;
    logic              cur_valid;
    state_e            cur_st;

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_next;
    logic              left_active_q, left_active_d;
    logic              right_active_q, right_active_d;
    logic              hazard_active_q, hazard_active_d;
    logic              left_done_q, left_done_d;
    logic              right_done_q, right_done_d;
    logic              hazard_done_q, hazard_done_d;
    logic              fault_q, fault_d;
    logic [1:0]        fault_code_q, fault_code_d;
    logic [CNT_W-1:0]  seq_count_q, seq_count_d;

    logic              same, pat_f, trans_f, hold_f, any_f, any_done;
    logic [1:0]        new_code;

    turn_signal_pattern_decode u_decode (
        .pattern   (Lights),
        .state_idx (cur_raw),
        .valid     (cur_valid)
    );

    assign cur_st = state_e'(cur_raw);

    always_comb begin
        same = cur_valid && (cur_st == state_q) && (cur_st != S_IDLE);

        // Counter saturates at the limit so a long hold cannot wrap back to legal.
        hold_next = '0;
        if (same) begin
            hold_next = (hold_q >= HOLD_LIM) ? hold_q : hold_q + 1'b1;
        end

        pat_f   = !cur_valid;
        trans_f = cur_valid && !same && !trans_legal(state_q, cur_st);
        hold_f  = cur_valid && same && (hold_next >= HOLD_LIM);
        any_f   = pat_f || trans_f || hold_f;

        new_code = FC_NONE;
        if (pat_f) begin
            new_code = FC_PATTERN;
        end else if (trans_f) begin
            new_code = FC_TRANS;
        end else if (hold_f) begin
            new_code = FC_HOLD;
        end

        // Illegal patterns drop to IDLE; other faults re-synchronise to what is on the bus.
        state_d = pat_f ? S_IDLE : cur_st;
        hold_d  = pat_f ? '0 : hold_next;

        left_active_d   = (state_d == S_L1) || (state_d == S_L2) || (state_d == S_L3);
        right_active_d  = (state_d == S_R1) || (state_d == S_R2) || (state_d == S_R3);
        hazard_active_d = (state_d == S_LR3);

        left_done_d   = !any_f && (state_q == S_L3)  && (cur_st == S_IDLE);
        right_done_d  = !any_f && (state_q == S_R3)  && (cur_st == S_IDLE);
        hazard_done_d = !any_f && (state_q == S_LR3) && (cur_st == S_IDLE);
        any_done      = left_done_d || right_done_d || hazard_done_d;

        seq_count_d = seq_count_q;
        if (any_done && (seq_count_q != {CNT_W{1'b1}})) begin
            seq_count_d = seq_count_q + 1'b1;
        end

        // A fault arriving with CLEAR wins over the clear and is captured fresh.
        fault_d      = CLEAR ? 1'b0 : fault_q;
        fault_code_d = CLEAR ? FC_NONE : fault_code_q;
        if (any_f) begin
            fault_d = 1'b1;
            if (!fault_q || CLEAR) begin
                fault_code_d = new_code;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state_q         <= S_IDLE;
            hold_q          <= '0;
            left_active_q   <= 1'b0;
            right_active_q  <= 1'b0;
            hazard_active_q <= 1'b0;
            left_done_q     <= 1'b0;
            right_done_q    <= 1'b0;
            hazard_done_q   <= 1'b0;
            fault_q         <= 1'b0;
            fault_code_q    <= FC_NONE;
            seq_count_q     <= '0;
        end else begin
            state_q         <= state_d;
            hold_q          <= hold_d;
            left_active_q   <= left_active_d;
            right_active_q  <= right_active_d;
            hazard_active_q <= hazard_active_d;
            left_done_q     <= left_done_d;
            right_done_q    <= right_done_d;
            hazard_done_q   <= hazard_done_d;
            fault_q         <= fault_d;
            fault_code_q    <= fault_code_d;
            seq_count_q     <= seq_count_d;
        end
    end

    assign LeftActive   = left_active_q;
    assign RightActive  = right_active_q;
    assign HazardActive = hazard_active_q;
    assign LeftDone     = left_done_q;
    assign RightDone    = right_done_q;
    assign HazardDone   = hazard_done_q;
    assign Fault        = fault_q;
    assign FaultCode    = fault_code_q;
    assign SeqCount     = seq_count_q;

endmodule

// File: tb/tb_turn_signal_monitor.sv
// tb/tb_turn_signal_monitor.sv - self-checking bench for turn_signal_monitor
module tb_turn_signal_monitor;

    logic       CLOCK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [1:6] Lights = 6'b000000;
    logic       CLEAR = 1'b0;

    logic       la, ra, ha, ld, rd, hd, flt;
    logic [1:0] fc;
    logic [7:0] cnt8;
    logic       la2, ra2, ha2, ld2, rd2, hd2, flt2;
    logic [1:0] fc2;
    logic [1:0] cnt2;

    int errors = 0;
    int checks = 0;

    always #5 CLOCK = ~CLOCK;

    turn_signal_monitor dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .Lights(Lights), .CLEAR(CLEAR),
        .LeftActive(la), .RightActive(ra), .HazardActive(ha),
        .LeftDone(ld), .RightDone(rd), .HazardDone(hd),
        .Fault(flt), .FaultCode(fc), .SeqCount(cnt8)
    );

    turn_signal_monitor #(.CNT_W(2)) dut_small (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .Lights(Lights), .CLEAR(CLEAR),
        .LeftActive(la2), .RightActive(ra2), .HazardActive(ha2),
        .LeftDone(ld2), .RightDone(rd2), .HazardDone(hd2),
        .Fault(flt2), .FaultCode(fc2), .SeqCount(cnt2)
    );

    typedef struct {
        logic       rst_n;
        logic       clr;
        logic [5:0] lights;
        logic [2:0] act;   // {Left, Right, Hazard}
        logic [2:0] done;  // {Left, Right, Hazard}
        logic       fault;
        logic [1:0] code;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic r, input logic c, input logic [5:0] l,
                               input logic [2:0] a, input logic [2:0] d,
                               input logic f, input logic [1:0] k, input logic [7:0] n);
        vec_t t;
        t.rst_n = r; t.clr = c; t.lights = l; t.act = a; t.done = d;
        t.fault = f; t.code = k; t.cnt = n;
        return t;
    endfunction

    task automatic step(input logic r, input logic c, input logic [5:0] l);
        RESET_N = r;
        CLEAR   = c;
        Lights  = l;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    initial begin
        logic [18:0] got_v, exp_v;
        logic [1:0]  exp2;

        // reset
        vecs.push_back(v(0,0,6'b000000, 3'b000,3'b000, 0,2'd0, 8'd0));
        vecs.push_back(v(0,0,6'b000000, 3'b000,3'b000, 0,2'd0, 8'd0));
        // left sequence
        vecs.push_back(v(1,0,6'b000000, 3'b000,3'b000, 0,2'd0, 8'd0));
        vecs.push_back(v(1,0,6'b100000, 3'b100,3'b000, 0,2'd0, 8'd0));
        vecs.push_back(v(1,0,6'b110000, 3'b100,3'b000, 0,2'd0, 8'd0));
        vecs.push_back(v(1,0,6'b111000, 3'b100,3'b000, 0,2'd0, 8'd0));
        vecs.push_back(v(1,0,6'b000000, 3'b000,3'b100, 0,2'd0, 8'd1));
        vecs.push_back(v(1,0,6'b000000, 3'b000,3'b000, 0,2'd0, 8'd1));
        // hazard abort of a right sequence
        vecs.push_back(v(1,0,6'b000001, 3'b010,3'b000, 0,2'd0, 8'd1));
        vecs.push_back(v(1,0,6'b000011, 3'b010,3'b000, 0,2'd0, 8'd1));
        vecs.push_back(v(1,0,6'b111111, 3'b001,3'b000, 0,2'd0, 8'd1));
        vecs.push_back(v(1,0,6'b000000, 3'b000,3'b001, 0,2'd0, 8'd2));
        vecs.push_back(v(1,0,6'b000000, 3'b000,3'b000, 0,2'd0, 8'd2));
        // illegal pattern, then illegal transition keeps first code, then clear
        vecs.push_back(v(1,0,6'b101010, 3'b000,3'b000, 1,2'd1, 8'd2));
        vecs.push_back(v(1,0,6'b111000, 3'b100,3'b000, 1,2'd1, 8'd2));
        vecs.push_back(v(1,0,6'b000000, 3'b000,3'b100, 1,2'd1, 8'd3));
        vecs.push_back(v(1,1,6'b000000, 3'b000,3'b000, 0,2'd0, 8'd3));
        // hold timeout with CLEAR in the fault cycle
        vecs.push_back(v(1,0,6'b100000, 3'b100,3'b000, 0,2'd0, 8'd3));
        vecs.push_back(v(1,1,6'b100000, 3'b100,3'b000, 1,2'd3, 8'd3));
        vecs.push_back(v(1,0,6'b110000, 3'b100,3'b000, 1,2'd3, 8'd3));
        vecs.push_back(v(1,0,6'b111000, 3'b100,3'b000, 1,2'd3, 8'd3));
        vecs.push_back(v(1,0,6'b000000, 3'b000,3'b100, 1,2'd3, 8'd4));
        // reset mid-sequence, then IDLE -> L3 is an illegal transition
        vecs.push_back(v(1,0,6'b100000, 3'b100,3'b000, 1,2'd3, 8'd4));
        vecs.push_back(v(1,0,6'b110000, 3'b100,3'b000, 1,2'd3, 8'd4));
        vecs.push_back(v(0,1,6'b110000, 3'b000,3'b000, 0,2'd0, 8'd0));
        vecs.push_back(v(1,0,6'b111000, 3'b100,3'b000, 1,2'd2, 8'd0));
        vecs.push_back(v(1,0,6'b000000, 3'b000,3'b100, 1,2'd2, 8'd1));
        // transition faults, clear races and priority
        vecs.push_back(v(1,1,6'b000000, 3'b000,3'b000, 0,2'd0, 8'd1));
        vecs.push_back(v(1,0,6'b100000, 3'b100,3'b000, 0,2'd0, 8'd1));
        vecs.push_back(v(1,0,6'b000001, 3'b010,3'b000, 1,2'd2, 8'd1));
        vecs.push_back(v(1,1,6'b000011, 3'b010,3'b000, 0,2'd0, 8'd1));
        vecs.push_back(v(1,0,6'b000011, 3'b010,3'b000, 1,2'd3, 8'd1));
        vecs.push_back(v(1,1,6'b000000, 3'b000,3'b000, 1,2'd2, 8'd1));
        vecs.push_back(v(1,1,6'b011000, 3'b000,3'b000, 1,2'd1, 8'd1));
        vecs.push_back(v(1,1,6'b000000, 3'b000,3'b000, 0,2'd0, 8'd1));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].clr, vecs[i].lights);
            exp2  = (vecs[i].cnt > 8'd3) ? 2'd3 : vecs[i].cnt[1:0];
            got_v = {la, ra, ha, ld, rd, hd, flt, fc, cnt8, cnt2};
            exp_v = {vecs[i].act, vecs[i].done, vecs[i].fault, vecs[i].code, vecs[i].cnt, exp2};
            check($sformatf("vec%0d", i), 32'(got_v), 32'(exp_v));
        end

        // saturation: five right sequences, narrow counter holds at 3
        step(0, 0, 6'b000000);
        check("sat_reset", {22'd0, cnt8, cnt2}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            step(1, 0, 6'b000001);
            check($sformatf("sat%0d_r1", k), {29'd0, ra, rd, flt}, 32'b100);
            step(1, 0, 6'b000011);
            check($sformatf("sat%0d_r2", k), {29'd0, ra, rd, flt}, 32'b100);
            step(1, 0, 6'b000111);
            check($sformatf("sat%0d_r3", k), {29'd0, ra, rd, flt}, 32'b100);
            step(1, 0, 6'b000000);
            check($sformatf("sat%0d_done", k), {29'd0, ra, rd, rd2}, 32'b011);
            check($sformatf("sat%0d_cnt8", k), {24'd0, cnt8}, 32'(k));
            check($sformatf("sat%0d_cnt2", k), {30'd0, cnt2}, (k > 3) ? 32'd3 : 32'(k));
        end
        step(1, 0, 6'b000000);
        check("sat_pulse_end", {29'd0, rd, rd2, flt}, 32'b000);
        check("sat_hold", {22'd0, cnt8, cnt2}, {22'd0, 8'd5, 2'd3});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
